pulse_train_gen: RTL and testbench

Multi-channel programmable pulse-train generator, the parametrised successor to the fixed four-edge burst pulse used in the clock test benches. Each channel, on a start request, emits a burst of N pulses, each `high_len` cycles high and `low_len` cycles low. Each channel reports busy/done status and can be aborted. The block is fully synchronous to the bench clock and drives stimulus signals for waveform and `.vcd` inspection exercises.

---
 rtl/pulse_gen_pkg.sv | 26 ++
 rtl/pulse_chan.sv | 206 ++++++++++++++++++++
 rtl/pulse_train_gen.sv | 64 ++++++
 tb/tb_pulse_train_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared definitions for the pulse-train generator.
//
// Contents:
//   PULSE_CNT_W  - default width of the length/count fields.
//   chan_state_e - per-channel FSM state encoding (IDLE, HIGH, LOW).
//   clamp_len    - maps a zero length to 1 so phase counters never load 0.
//
// Optional feature macro used by the files that import this package:
//   PULSE_GEN_CONT_EN - continuous (auto-restart) burst mode.

package pulse_gen_pkg;

    localparam int unsigned PULSE_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } chan_state_e;

    // Works on a 32-bit container; callers cast back to their field width.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/pulse_chan.sv
// pulse_chan: one channel of the pulse-train generator.
//
// On an accepted start the channel captures its length/count inputs and emits
// 'count' pulses, each max(high_len,1) cycles high and max(low_len,1) cycles
// low, with no trailing low phase. stop aborts a burst without a done strobe.
// count=0 on start produces only a done strobe one edge later.
//
// Build option: PULSE_GEN_CONT_EN adds the 'cont' input. When cont=1 at the end
// of a burst, done still strobes but the channel runs a low phase and then
// re-captures its inputs and starts a new burst, keeping busy high.
//
// Ports:
//   clock    - clock, all state changes on posedge
//   reset_n  - asynchronous active-low reset
//   start    - burst request (level, sampled at posedge)
//   stop     - abort request (sampled at posedge)
//   cont     - continuous mode (only with PULSE_GEN_CONT_EN)
//   high_len - high-phase length in cycles
//   low_len  - low-phase length in cycles
//   count    - pulses per burst
//   signal   - registered pulse output
//   busy     - registered, high while a burst runs
//   done     - registered one-cycle completion strobe

module pulse_chan
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = PULSE_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
`ifdef PULSE_GEN_CONT_EN
    input  logic             cont,
`endif
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] count,
    output logic             signal,
    output logic             busy,
    output logic             done
);

    chan_state_e state_q, state_d;

    logic [CNT_W-1:0] phase_q, phase_d;  // cycles left in the current phase
    logic [CNT_W-1:0] pulse_q, pulse_d;  // pulses left, including the current one
    logic [CNT_W-1:0] high_q,  high_d;   // captured high_len
    logic [CNT_W-1:0] low_q,   low_d;    // captured low_len
    logic             zero_pend_q, zero_pend_d;  // count=0 start, done owed next edge

`ifdef PULSE_GEN_CONT_EN
    logic             tail_q, tail_d;    // LOW phase between chained bursts
`endif

    logic             signal_q, signal_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [CNT_W-1:0] high_in_clamped;
    logic [CNT_W-1:0] high_q_clamped;
    logic [CNT_W-1:0] low_q_clamped;

    assign high_in_clamped = CNT_W'(clamp_len(32'(high_len)));
    assign high_q_clamped  = CNT_W'(clamp_len(32'(high_q)));
    assign low_q_clamped   = CNT_W'(clamp_len(32'(low_q)));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pulse_d     = pulse_q;
        high_d      = high_q;
        low_d       = low_q;
        zero_pend_d = 1'b0;
        done_d      = zero_pend_q;
`ifdef PULSE_GEN_CONT_EN
        tail_d      = tail_q;
`endif

        unique case (state_q)
            IDLE: begin
                // stop wins over a simultaneous start.
                if (start && !stop) begin
                    high_d = high_len;
                    low_d  = low_len;
                    if (count == '0) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d = HIGH;
                        phase_d = high_in_clamped;
                        pulse_d = count;
                    end
                end
            end

            HIGH: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = '0;
                    pulse_d = '0;
`ifdef PULSE_GEN_CONT_EN
                    tail_d  = 1'b0;
`endif
                end else if (phase_q > CNT_W'(1)) begin
                    phase_d = phase_q - CNT_W'(1);
                end else if (pulse_q > CNT_W'(1)) begin
                    state_d = LOW;
                    phase_d = low_q_clamped;
                    pulse_d = pulse_q - CNT_W'(1);
                end else begin
                    // Last pulse ends here: start on this edge is ignored.
                    done_d  = 1'b1;
                    state_d = IDLE;
                    phase_d = '0;
                    pulse_d = '0;
`ifdef PULSE_GEN_CONT_EN
                    if (cont) begin
                        state_d = LOW;
                        phase_d = low_q_clamped;
                        tail_d  = 1'b1;
                    end
`endif
                end
            end

            LOW: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = '0;
                    pulse_d = '0;
`ifdef PULSE_GEN_CONT_EN
                    tail_d  = 1'b0;
`endif
                end else if (phase_q > CNT_W'(1)) begin
                    phase_d = phase_q - CNT_W'(1);
`ifdef PULSE_GEN_CONT_EN
                end else if (tail_q) begin
                    // Chained burst: re-capture the live inputs.
                    tail_d = 1'b0;
                    high_d = high_len;
                    low_d  = low_len;
                    if (count == '0) begin
                        state_d = IDLE;
                        phase_d = '0;
                        pulse_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HIGH;
                        phase_d = high_in_clamped;
                        pulse_d = count;
                    end
`endif
                end else begin
                    state_d = HIGH;
                    phase_d = high_q_clamped;
                end
            end

            default: begin
                state_d = IDLE;
                phase_d = '0;
                pulse_d = '0;
            end
        endcase

        // Outputs follow the next state so they change on the same edge.
        signal_d = (state_d == HIGH);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            pulse_q     <= '0;
            high_q      <= '0;
            low_q       <= '0;
            zero_pend_q <= 1'b0;
`ifdef PULSE_GEN_CONT_EN
            tail_q      <= 1'b0;
`endif
            signal_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pulse_q     <= pulse_d;
            high_q      <= high_d;
            low_q       <= low_d;
            zero_pend_q <= zero_pend_d;
`ifdef PULSE_GEN_CONT_EN
            tail_q      <= tail_d;
`endif
            signal_q    <= signal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign signal = signal_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: multi-channel programmable pulse-train generator.
//
// Instantiates CHANNELS independent pulse_chan channels. Channel c uses bit c
// of the per-channel vectors and bits [c*CNT_W +: CNT_W] of the packed
// length/count buses.
//
// Build option: PULSE_GEN_CONT_EN adds the per-channel 'cont' input
// (continuous burst mode); without it every burst is one-shot.
//
// Ports:
//   clock    - clock, all state changes on posedge
//   reset_n  - asynchronous active-low reset
//   start    - per-channel burst request
//   stop     - per-channel abort
//   cont     - per-channel continuous mode (only with PULSE_GEN_CONT_EN)
//   high_len - packed per-channel high-phase lengths
//   low_len  - packed per-channel low-phase lengths
//   count    - packed per-channel pulses per burst
//   signal   - per-channel registered pulse outputs
//   busy     - per-channel registered busy flags
//   done     - per-channel registered one-cycle done strobes

module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = PULSE_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
`ifdef PULSE_GEN_CONT_EN
    input  logic [CHANNELS-1:0]       cont,
`endif
    input  logic [CHANNELS*CNT_W-1:0] high_len,
    input  logic [CHANNELS*CNT_W-1:0] low_len,
    input  logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       signal,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pulse_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .start   (start[c]),
            .stop    (stop[c]),
`ifdef PULSE_GEN_CONT_EN
            .cont    (cont[c]),
`endif
            .high_len(high_len[c*CNT_W +: CNT_W]),
            .low_len (low_len[c*CNT_W +: CNT_W]),
            .count   (count[c*CNT_W +: CNT_W]),
            .signal  (signal[c]),
            .busy    (busy[c]),
            .done    (done[c])
        );
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for pulse_train_gen: the stimulus process drives inputs on
// the falling edge and queues the expected {signal,busy,done} for the next
// rising edge; the monitor pops and compares shortly after each rising edge.

module tb_pulse_train_gen;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] start;
    logic [CH-1:0] stop;
`ifdef PULSE_GEN_CONT_EN
    logic [CH-1:0] cont;
`endif
    logic [CH*W-1:0] high_len;
    logic [CH*W-1:0] low_len;
    logic [CH*W-1:0] count;
    logic [CH-1:0] signal;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;

    typedef struct {
        logic [CH-1:0] sig;
        logic [CH-1:0] bsy;
        logic [CH-1:0] dn;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    pulse_train_gen #(
        .CHANNELS(CH),
        .CNT_W   (W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
`ifdef PULSE_GEN_CONT_EN
        .cont    (cont),
`endif
        .high_len(high_len),
        .low_len (low_len),
        .count   (count),
        .signal  (signal),
        .busy    (busy),
        .done    (done)
    );

    task automatic compare(input string name, input logic [3*CH-1:0] act,
                           input logic [3*CH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: sig/busy/done got %b want %b", name, act, req);
        end
    endtask

    // Drive start/stop for the next rising edge and queue its expected outputs.
    task automatic tick(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                        input logic [CH-1:0] es, input logic [CH-1:0] eb,
                        input logic [CH-1:0] ed, input string nm);
        exp_t e;
        @(negedge clock);
        start = st;
        stop  = sp;
        e.sig  = es;
        e.bsy  = eb;
        e.dn   = ed;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic set_ch(input int c, input int h, input int l, input int n);
        high_len[c*W +: W] = W'(h);
        low_len[c*W +: W]  = W'(l);
        count[c*W +: W]    = W'(n);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                compare(e.name, {signal, busy, done}, {e.sig, e.bsy, e.dn});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        reset_n  = 1'b0;
        start    = '0;
        stop     = '0;
        high_len = '0;
        low_len  = '0;
        count    = '0;
`ifdef PULSE_GEN_CONT_EN
        cont     = '0;
`endif
        #1;
        compare("reset_state", {signal, busy, done}, '0);
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "reset_hold");
        reset_n = 1'b1;

        // H=3 L=3 N=2; mid-burst start re-assert and high_len change are ignored,
        // as is start on the final edge.
        set_ch(0, 3, 3, 2);
        tick(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, "b_k0");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "b_k1");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "b_k2");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "b_k3");
        set_ch(0, 7, 3, 2);
        tick(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, "b_k4");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "b_k5");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "b_k6");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "b_k7");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "b_k8");
        tick(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, "b_k9_done");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "b_k10");

        // Zero lengths clamp to 1: 1,0,1,0,1 then done.
        set_ch(0, 0, 0, 3);
        tick(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, "z_k0");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "z_k1");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "z_k2");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "z_k3");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "z_k4");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, "z_k5_done");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "z_k6");

        // count=0: done at k+1, busy never set.
        set_ch(0, 4, 4, 0);
        tick(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "c0_k0");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, "c0_k1_done");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "c0_k2");

        // Abort: H=5 L=2 N=4, stop at k+7 as pulse 1 would rise.
        set_ch(0, 5, 2, 4);
        tick(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, "ab_k0");
        for (int i = 1; i < 5; i++)
            tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, $sformatf("ab_k%0d", i));
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ab_k5");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ab_k6");
        tick(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "ab_k7_stop");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "ab_k8");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "ab_k9");

        // start+stop together in IDLE: nothing happens.
        set_ch(0, 2, 2, 1);
        tick(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, "ss_k0");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "ss_k1");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "ss_k2");

        // Independence: ch0 H=2 L=1 N=3, ch1 H=4 L=4 N=1, same start edge.
        set_ch(0, 2, 1, 3);
        set_ch(1, 4, 4, 1);
        tick(2'b11, 2'b00, 2'b11, 2'b11, 2'b00, "ind_k0");
        tick(2'b00, 2'b00, 2'b11, 2'b11, 2'b00, "ind_k1");
        tick(2'b00, 2'b00, 2'b10, 2'b11, 2'b00, "ind_k2");
        tick(2'b00, 2'b00, 2'b11, 2'b11, 2'b00, "ind_k3");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b10, "ind_k4");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ind_k5");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "ind_k6");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "ind_k7");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, "ind_k8");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "ind_k9");

        // Asynchronous reset mid-burst, then start accepted after release.
        set_ch(0, 3, 3, 2);
        tick(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, "rm_k0");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "rm_k1");
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        compare("rm_async", {signal, busy, done}, '0);
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "rm_hold");
        reset_n = 1'b1;
        tick(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, "rm_restart");
        tick(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "rm_stop");

`ifdef PULSE_GEN_CONT_EN
        // Continuous: H=1 L=2 N=2 gives 1,0,0 repeating; drop cont to end.
        set_ch(0, 1, 2, 2);
        cont = 2'b01;
        tick(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, "ct_k0");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ct_k1");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ct_k2");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "ct_k3");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b01, "ct_k4_done");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ct_k5");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "ct_k6");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ct_k7");
        tick(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "ct_k8");
        tick(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, "ct_k9");
        cont = 2'b00;
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, "ct_k10_done");
        tick(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "ct_k11");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clock);
            #3;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
